sram_arbiter: RTL

//  Sequences the single shared external SRAM between instruction fetch (IF) and
//  the MEM stage (load/store). Owns all SRAM control pins, runs multi-cycle read
//  and write timing, and raises stall while a MEM access is in flight.

---
 rtl/sram_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Shared external SRAM sequencer: MEM-stage loads/stores take priority over
// instruction fetch; all SRAM pins, read data and completion pulses are registered.
//
// state    | meaning
// IDLE     | bus released, arbitrate wr > rd > fetch
// RD       | MEM load strobe, waiting RD_WAIT cycles
// FETCH    | IF fetch strobe, waiting RD_WAIT cycles
// WR_SETUP | addr/data driven, we_n high (setup)
// WR_PULSE | we_n low for WE_CYCLES cycles
// WR_HOLD  | we_n high, addr/data still driven (hold)
module sram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RD_WAIT   = 1,
    parameter int WE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    localparam int CNT_MAX = (RD_WAIT > WE_CYCLES) ? RD_WAIT : WE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WE_CNT  = CNT_W'(WE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        FETCH,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             take_wr;
    logic             take_rd;
    logic             take_if;

    assign stall_o = (mem_rd_i | mem_wr_i) & ~mem_done_o;

    // A requester still showing its completion pulse has not yet dropped its request.
    assign take_wr = mem_wr_i & ~mem_done_o;
    assign take_rd = mem_rd_i & ~mem_done_o;
    assign take_if = if_req_i & ~if_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sram_addr_o  <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            if_data_o    <= '0;
            if_ready_o   <= 1'b0;
            mem_rdata_o  <= '0;
            mem_done_o   <= 1'b0;
        end else begin
            if_ready_o <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_wr) begin
                        sram_addr_o  <= mem_addr_i;
                        sram_dq_o    <= mem_wdata_i;
                        sram_ce_n_o  <= 1'b0;
                        sram_dq_oe_o <= 1'b1;
                        state        <= WR_SETUP;
                    end else if (take_rd) begin
                        sram_addr_o <= mem_addr_i;
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= 1'b0;
                        cnt         <= RD_CNT;
                        state       <= RD;
                    end else if (take_if) begin
                        sram_addr_o <= if_addr_i;
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= 1'b0;
                        cnt         <= RD_CNT;
                        state       <= FETCH;
                    end
                end
                RD, FETCH: begin
                    if (cnt == CNT_ONE) begin
                        if (state == RD) begin
                            mem_rdata_o <= sram_dq_i;
                            mem_done_o  <= 1'b1;
                        end else begin
                            if_data_o  <= sram_dq_i;
                            if_ready_o <= 1'b1;
                        end
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_SETUP: begin
                    sram_we_n_o <= 1'b0;
                    cnt         <= WE_CNT;
                    state       <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == CNT_ONE) begin
                        sram_we_n_o <= 1'b1;
                        state       <= WR_HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_HOLD: begin
                    mem_done_o   <= 1'b1;
                    sram_dq_oe_o <= 1'b0;
                    sram_ce_n_o  <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
